// File: rtl/wait_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wait_buffer
// Purpose  : Dispatcher wait buffer. Parks decoded instructions until every
//            source operand is available, snoops the EU result broadcast to
//            wake operands, and issues ready instructions oldest-first over a
//            valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module wait_buffer #(
    parameter int NumTags           = 8,
    parameter int OperandsPerInst   = 2,
    parameter int WaitBufferEntries = 4,
    parameter int PayloadWidth      = 32,
    parameter int TagWidth          = $clog2(NumTags)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    output logic                                space_available_o,
    input  logic                                insert_i,
    input  logic [TagWidth-1:0]                 tag_i,
    input  logic [PayloadWidth-1:0]             payload_i,
    input  logic [OperandsPerInst-1:0]          operands_ready_i,
    input  logic [OperandsPerInst*TagWidth-1:0] operands_tag_i,
    input  logic                                eu_valid_i,
    input  logic [TagWidth-1:0]                 eu_tag_i,
    output logic                                disp_valid_o,
    input  logic                                disp_ready_i,
    output logic [TagWidth-1:0]                 disp_tag_o,
    output logic [PayloadWidth-1:0]             disp_payload_o
);

    localparam int c_IDX_W = (WaitBufferEntries > 1) ? $clog2(WaitBufferEntries) : 1;

    // Per-entry storage
    logic [WaitBufferEntries-1:0]                     r_valid;
    logic [TagWidth-1:0]                              r_tag      [WaitBufferEntries];
    logic [PayloadWidth-1:0]                          r_payload  [WaitBufferEntries];
    logic [OperandsPerInst-1:0]                       r_op_ready [WaitBufferEntries];
    logic [OperandsPerInst-1:0][TagWidth-1:0]         r_op_tag   [WaitBufferEntries];
    // r_older[i][j] = 1 : entry i was inserted before entry j
    logic [WaitBufferEntries-1:0]                     r_older    [WaitBufferEntries];

    // Stream lock: keeps the presented entry fixed while downstream stalls
    logic                                             r_lock_valid;
    logic [c_IDX_W-1:0]                               r_lock_idx;

    logic [WaitBufferEntries-1:0]                     w_eligible;
    logic [WaitBufferEntries-1:0]                     w_has_older;
    logic                                             w_oldest_found;
    logic [c_IDX_W-1:0]                               w_oldest_idx;
    logic [c_IDX_W-1:0]                               w_sel_idx;
    logic                                             w_disp_valid;
    logic                                             w_fire;
    logic                                             w_insert;
    logic [c_IDX_W-1:0]                               w_free_idx;
    logic [OperandsPerInst-1:0]                       w_ins_ready;

    // Eligibility from registered state only, plus "an older eligible entry exists"
    always_comb begin
        w_eligible  = '0;
        w_has_older = '0;
        for (int i = 0; i < WaitBufferEntries; i++) begin
            w_eligible[i] = r_valid[i] & (&r_op_ready[i]);
        end
        for (int i = 0; i < WaitBufferEntries; i++) begin
            for (int j = 0; j < WaitBufferEntries; j++) begin
                if (w_eligible[j] && r_older[j][i]) begin
                    w_has_older[i] = 1'b1;
                end
            end
        end
    end

    // Oldest eligible entry; the lock overrides it while the stream is stalled
    always_comb begin
        w_oldest_found = 1'b0;
        w_oldest_idx   = '0;
        for (int i = WaitBufferEntries - 1; i >= 0; i--) begin
            if (w_eligible[i] && !w_has_older[i]) begin
                w_oldest_found = 1'b1;
                w_oldest_idx   = c_IDX_W'(i);
            end
        end
        w_sel_idx    = r_lock_valid ? r_lock_idx : w_oldest_idx;
        w_disp_valid = r_lock_valid | w_oldest_found;
    end

    // Lowest free slot and insert-time operand readiness (incl. same-cycle broadcast)
    always_comb begin
        w_free_idx  = '0;
        w_ins_ready = '0;
        for (int i = WaitBufferEntries - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
        end
        for (int op = 0; op < OperandsPerInst; op++) begin
            w_ins_ready[op] = operands_ready_i[op] |
                (eu_valid_i && (eu_tag_i == operands_tag_i[op*TagWidth +: TagWidth]));
        end
    end

    assign space_available_o = ~(&r_valid);
    assign w_insert          = insert_i & space_available_o;
    assign w_fire            = w_disp_valid & disp_ready_i;
    assign disp_valid_o      = w_disp_valid;
    assign disp_tag_o        = w_disp_valid ? r_tag[w_sel_idx]     : '0;
    assign disp_payload_o    = w_disp_valid ? r_payload[w_sel_idx] : '0;

    // Entry state: wake-up, insert into lowest free slot, retire on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < WaitBufferEntries; i++) begin
                r_tag[i]      <= '0;
                r_payload[i]  <= '0;
                r_op_ready[i] <= '0;
                r_op_tag[i]   <= '0;
                r_older[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < WaitBufferEntries; i++) begin
                for (int op = 0; op < OperandsPerInst; op++) begin
                    if (eu_valid_i && r_valid[i] && !r_op_ready[i][op] &&
                        (r_op_tag[i][op] == eu_tag_i)) begin
                        r_op_ready[i][op] <= 1'b1;
                    end
                end
            end
            if (w_insert) begin
                r_valid[w_free_idx]    <= 1'b1;
                r_tag[w_free_idx]      <= tag_i;
                r_payload[w_free_idx]  <= payload_i;
                r_op_ready[w_free_idx] <= w_ins_ready;
                r_op_tag[w_free_idx]   <= operands_tag_i;
                r_older[w_free_idx]    <= '0;
                // Every entry valid right now is older than the newcomer
                for (int i = 0; i < WaitBufferEntries; i++) begin
                    r_older[i][w_free_idx] <= r_valid[i];
                end
            end
            // Retirement comes last so it wins over the insert's column update
            if (w_fire) begin
                r_valid[w_sel_idx] <= 1'b0;
                r_older[w_sel_idx] <= '0;
                for (int i = 0; i < WaitBufferEntries; i++) begin
                    r_older[i][w_sel_idx] <= 1'b0;
                end
            end
        end
    end

    // Lock the presented entry while stalled, release on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
        end else if (w_fire) begin
            r_lock_valid <= 1'b0;
        end else if (w_disp_valid) begin
            r_lock_valid <= 1'b1;
            r_lock_idx   <= w_sel_idx;
        end
    end

    // Inserting into a full buffer is a protocol error; the insert is dropped
    a_no_insert_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni) insert_i |-> space_available_o);

    // Presented instruction must hold steady until accepted
    a_stall_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (disp_valid_o && !disp_ready_i) |=>
        (disp_valid_o && $stable(disp_tag_o) && $stable(disp_payload_o)));

    // No two live entries may carry the same result tag
    for (genvar gi = 0; gi < WaitBufferEntries; gi++) begin : g_uniq_i
        for (genvar gj = gi + 1; gj < WaitBufferEntries; gj++) begin : g_uniq_j
            a_unique_tag : assert property (
                @(posedge clk_i) disable iff (!rst_ni)
                !(r_valid[gi] && r_valid[gj] && (r_tag[gi] == r_tag[gj])));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wait_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wait_buffer
// Purpose  : Self-checking bench for wait_buffer. A queue-based reference
//            model (entries kept in insertion order) predicts the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wait_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        space_available;
    logic        insert;
    logic [2:0]  tag;
    logic [31:0] payload;
    logic [1:0]  op_ready;
    logic [5:0]  op_tag;
    logic        eu_valid;
    logic [2:0]  eu_tag;
    logic        disp_valid;
    logic        disp_ready;
    logic [2:0]  disp_tag;
    logic [31:0] disp_payload;

    int checks   = 0;
    int failures = 0;

    wait_buffer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .space_available_o(space_available),
        .insert_i         (insert),
        .tag_i            (tag),
        .payload_i        (payload),
        .operands_ready_i (op_ready),
        .operands_tag_i   (op_tag),
        .eu_valid_i       (eu_valid),
        .eu_tag_i         (eu_tag),
        .disp_valid_o     (disp_valid),
        .disp_ready_i     (disp_ready),
        .disp_tag_o       (disp_tag),
        .disp_payload_o   (disp_payload)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]       tag;
        logic [31:0]      pl;
        logic [1:0]       rdy;
        logic [1:0][2:0]  wt;
    } ent_t;

    ent_t       q[$];          // oldest at index 0
    bit         m_locked;
    logic [2:0] m_lock_tag;

    function automatic void model_reset();
        q.delete();
        m_locked = 1'b0;
        m_lock_tag = '0;
    endfunction

    function automatic int m_sel();
        for (int k = 0; k < q.size(); k++) begin
            if (m_locked) begin
                if (q[k].tag == m_lock_tag) return k;
            end else if (&q[k].rdy) begin
                return k;
            end
        end
        return -1;
    endfunction

    function automatic logic [36:0] exp_vec();
        int s = m_sel();
        return {q.size() < 4, s >= 0, (s >= 0) ? q[s].tag : 3'd0, (s >= 0) ? q[s].pl : 32'd0};
    endfunction

    function automatic logic [36:0] obs_vec();
        return {space_available, disp_valid, disp_valid ? disp_tag : 3'd0,
                disp_valid ? disp_payload : 32'd0};
    endfunction

    function automatic bit in_q(logic [2:0] t);
        foreach (q[k]) if (q[k].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    function automatic void model_step();
        int         s  = m_sel();
        bit         pv = (s >= 0);
        logic [2:0] st = pv ? q[s].tag : 3'd0;
        bit         do_ins = insert && (q.size() < 4);
        ent_t       e;
        if (eu_valid) begin
            for (int k = 0; k < q.size(); k++) begin
                e = q[k];
                for (int op = 0; op < 2; op++)
                    if (!e.rdy[op] && e.wt[op] == eu_tag) e.rdy[op] = 1'b1;
                q[k] = e;
            end
        end
        if (pv && disp_ready) begin
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].tag == st) begin
                    q.delete(k);
                    break;
                end
            end
            m_locked = 1'b0;
        end else if (pv) begin
            m_locked   = 1'b1;
            m_lock_tag = st;
        end
        if (do_ins) begin
            e.tag = tag;
            e.pl  = payload;
            e.wt  = op_tag;
            for (int op = 0; op < 2; op++)
                e.rdy[op] = op_ready[op] | (eu_valid && eu_tag == op_tag[op*3 +: 3]);
            q.push_back(e);
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(bit ins, logic [2:0] t, logic [31:0] pl, logic [1:0] rdy,
                         logic [5:0] ot, bit ev, logic [2:0] et, bit dr);
        insert = ins; tag = t; payload = pl; op_ready = rdy; op_tag = ot;
        eu_valid = ev; eu_tag = et; disp_ready = dr;
    endtask

    task automatic idle(bit dr);
        drive(1'b0, 3'd0, 32'd0, 2'b00, 6'd0, 1'b0, 3'd0, dr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (space_available !== 1'b1) begin failures++; $display("FAIL reset_space got=%b want=1", space_available); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", disp_valid); end
        checks++; if (disp_tag !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d want=0", disp_tag); end
        checks++; if (disp_payload !== 32'd0) begin failures++; $display("FAIL reset_payload got=%h want=0", disp_payload); end
    endtask

    task automatic test_single_ready();
        drive(1'b1, 3'd3, 32'hCAFE0003, 2'b11, 6'd0, 1'b0, 3'd0, 1'b0);
        checks++; if (disp_valid !== 1'b0 || space_available !== 1'b1) begin failures++; $display("FAIL single_pre got=%b%b want=10", space_available, disp_valid); end
        tick();
        idle(1'b1);
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL single_model got=%h want=%h", obs_vec(), exp_vec()); end
        checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd3 || space_available !== 1'b1) begin failures++; $display("FAIL single_issue got v=%b t=%0d s=%b want v=1 t=3 s=1", disp_valid, disp_tag, space_available); end
        tick();
        checks++; if (disp_valid !== 1'b0 || space_available !== 1'b1) begin failures++; $display("FAIL single_freed got v=%b s=%b want v=0 s=1", disp_valid, space_available); end
    endtask

    task automatic test_wake_latency();
        idle(1'b0);
        drive(1'b1, 3'd1, 32'h11110001, 2'b10, {3'd0, 3'd5}, 1'b0, 3'd0, 1'b1);
        tick();
        idle(1'b1);
        for (int c = 0; c < 2; c++) begin
            checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wake_wait cycle=%0d got=%b want=0", c, disp_valid); end
            if (c == 0) tick();
        end
        drive(1'b0, 3'd0, 32'd0, 2'b00, 6'd0, 1'b1, 3'd5, 1'b1);
        tick();
        idle(1'b1);
        checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd1) begin failures++; $display("FAIL wake_issue got v=%b t=%0d want v=1 t=1", disp_valid, disp_tag); end
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL wake_model got=%h want=%h", obs_vec(), exp_vec()); end
        tick();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL wake_done got=%b want=0", disp_valid); end
    endtask

    task automatic test_insert_wake();
        drive(1'b1, 3'd2, 32'h22220002, 2'b01, {3'd6, 3'd0}, 1'b1, 3'd6, 1'b0);
        tick();
        idle(1'b1);
        checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd2) begin failures++; $display("FAIL insert_wake got v=%b t=%0d want v=1 t=2", disp_valid, disp_tag); end
        tick();
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL insert_wake_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_fill_order();
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 3'(t), 32'hF0000000 + t, 2'b00, {3'd7, 3'd7}, 1'b0, 3'd0, 1'b1);
            checks++; if (space_available !== 1'b1) begin failures++; $display("FAIL fill_space slot=%0d got=%b want=1", t, space_available); end
            tick();
        end
        idle(1'b1);
        checks++; if (space_available !== 1'b0 || disp_valid !== 1'b0) begin failures++; $display("FAIL fill_full got s=%b v=%b want s=0 v=0", space_available, disp_valid); end
        tick();
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL fill_idle_model got=%h want=%h", obs_vec(), exp_vec()); end
        drive(1'b0, 3'd0, 32'd0, 2'b00, 6'd0, 1'b1, 3'd7, 1'b1);
        tick();
        idle(1'b1);
        for (int t = 0; t < 4; t++) begin
            checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'(t)) begin failures++; $display("FAIL fill_order step=%0d got v=%b t=%0d want v=1 t=%0d", t, disp_valid, disp_tag, t); end
            checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL fill_order_model got=%h want=%h", obs_vec(), exp_vec()); end
            tick();
        end
        checks++; if (disp_valid !== 1'b0 || space_available !== 1'b1) begin failures++; $display("FAIL fill_drained got v=%b s=%b want v=0 s=1", disp_valid, space_available); end
    endtask

    task automatic test_lock();
        drive(1'b1, 3'd0, 32'h00000A00, 2'b10, {3'd0, 3'd6}, 1'b0, 3'd0, 1'b0);
        tick();
        drive(1'b1, 3'd4, 32'h00000A04, 2'b11, 6'd0, 1'b0, 3'd0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 2'b00, 6'd0, 1'b1, 3'd6, 1'b0);
        checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd4) begin failures++; $display("FAIL lock_first got v=%b t=%0d want v=1 t=4", disp_valid, disp_tag); end
        tick();
        idle(1'b0);
        for (int c = 0; c < 2; c++) begin
            checks++; if (disp_tag !== 3'd4 || disp_payload !== 32'h00000A04) begin failures++; $display("FAIL lock_hold cycle=%0d got t=%0d p=%h want t=4 p=00000a04", c, disp_tag, disp_payload); end
            checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL lock_model got=%h want=%h", obs_vec(), exp_vec()); end
            if (c == 0) tick();
        end
        idle(1'b1);
        tick();
        checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd0) begin failures++; $display("FAIL lock_next got v=%b t=%0d want v=1 t=0", disp_valid, disp_tag); end
        tick();
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL lock_done got=%b want=0", disp_valid); end
    endtask

    task automatic test_reset_mid();
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, 3'(t), 32'hB0000000 + t, 2'b11, 6'd0, 1'b0, 3'd0, 1'b0);
            tick();
        end
        idle(1'b0);
        checks++; if (disp_valid !== 1'b1 || space_available !== 1'b1 || disp_tag !== 3'd1) begin failures++; $display("FAIL rstmid_pre got v=%b s=%b t=%0d want v=1 s=1 t=1", disp_valid, space_available, disp_tag); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (disp_valid !== 1'b0 || space_available !== 1'b1) begin failures++; $display("FAIL rstmid_async got v=%b s=%b want v=0 s=1", disp_valid, space_available); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++; if (disp_valid !== 1'b0 || space_available !== 1'b1) begin failures++; $display("FAIL rstmid_after cycle=%0d got v=%b s=%b want v=0 s=1", c, disp_valid, space_available); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [2:0] t;
        for (int c = 0; c < 600; c++) begin
            checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL random cycle=%0d got=%h want=%h", c, obs_vec(), exp_vec()); end
            t = 3'($urandom_range(0, 7));
            while (in_q(t)) t = 3'($urandom_range(0, 7));
            drive((q.size() < 4) && ($urandom_range(0, 1) == 1), t, $urandom,
                  2'($urandom_range(0, 3)), 6'($urandom), ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 4) < 3));
            tick();
        end
        idle(1'b1);
    endtask

    initial begin
        idle(1'b0);
        model_reset();
        test_reset();
        test_single_ready();
        test_wake_latency();
        test_insert_wake();
        test_fill_order();
        test_lock();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wait_buffer.md
Name: wait_buffer

Overview:
- Holds decoded instructions in the dispatcher until all of their source operands are available, then issues them to the execution units.
- Sits between the decoder/register-table pair and the operand-collect/execute stage.
- Consumes the per-operand ready flags and producer tags that the register table returns on insert.
- Snoops the execution-unit result broadcast (eu_valid_i/eu_tag_i) to wake up waiting operands.
- Issues ready instructions oldest-first over a valid/ready stream.

Parameters:
- NumTags, 8, number of in-flight producer tags; TagWidth = $clog2(NumTags)
- OperandsPerInst, 2, source operands per instruction
- WaitBufferEntries, 4, instruction slots
- PayloadWidth, 32, opaque decoded-instruction payload bits
- TagWidth, $clog2(NumTags), derived; not to be overridden

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- space_available_o  out  1  at least one free slot (registered state only)
- insert_i  in  1  insert instruction this cycle
- tag_i  in  TagWidth  tag of the inserted instruction (its own result tag)
- payload_i  in  PayloadWidth  decoded instruction
- operands_ready_i  in  OperandsPerInst  per-operand ready from register table
- operands_tag_i  in  OperandsPerInst*TagWidth  producer tag for each not-ready operand
- eu_valid_i  in  1  execution-unit result valid
- eu_tag_i  in  TagWidth  tag of the completing producer
- disp_valid_o  out  1  instruction available for dispatch
- disp_ready_i  in  1  downstream accepts
- disp_tag_o  out  TagWidth  tag of the dispatched instruction
- disp_payload_o  out  PayloadWidth  payload of the dispatched instruction

Behaviour:
- Per-entry state:
  - valid bit
  - tag, payload
  - per-operand ready bits and producer tags
  - age-matrix row: older[i][j] = 1 means entry i was inserted before entry j
- Reset: all valid = 0, age matrix = 0, lock register clear.
  - Outputs after reset: space_available_o = 1, disp_valid_o = 0, disp_tag_o = 0, disp_payload_o = 0.
- space_available_o = !(&valid_q). It does not account for a dispatch in the same cycle.
- Insert (insert_i && space_available_o):
  - Write the lowest-index free slot.
  - An operand is stored ready if operands_ready_i[op] is set, or if eu_valid_i and eu_tag_i equal operands_tag_i[op] in the same cycle.
  - Update the age matrix: the new entry is younger than every currently valid entry.
- insert_i while space_available_o = 0 is an error: it is ignored and flagged by an assertion.
- Wake-up: each cycle eu_valid_i is high, every valid entry with a not-ready operand whose stored tag equals eu_tag_i sets that operand ready in the next state.
  - The same broadcast may wake multiple entries and multiple operands.
- Eligibility: an entry is eligible when it is valid and all its operands are ready, computed from registered state.
  - Insert-to-dispatch latency is at least 1 cycle.
  - Wake-to-dispatch latency is 1 cycle.
- Selection: the eligible entry with no older eligible entry.
  - disp_valid_o = any eligible entry; outputs are driven combinationally from the selected slot.
- Stream stability:
  - If disp_valid_o && !disp_ready_i, the selected index is registered (locked).
  - The locked entry stays selected until the handshake, even if an older entry becomes eligible.
  - disp_tag_o and disp_payload_o must not change while disp_valid_o is high and not yet accepted.
- Handshake (disp_valid_o && disp_ready_i): clear the selected entry's valid bit and the lock, and clear its age-matrix row and column.
- Simultaneous insert + dispatch in the same cycle: both take effect.
  - The freed slot is not reusable in that same cycle.
- Simultaneous wake-up + insert of an operand waiting on eu_tag_i: the operand is stored ready.
- Full with nothing eligible: space_available_o = 0 and disp_valid_o = 0 until an EU broadcast wakes an entry.
- Reset mid-operation: all entries are discarded immediately on assertion (asynchronous).
- Assertions:
  - Two valid entries never share a tag.
  - No insert while full.
  - The outputs are stable while the stream is stalled.

Test Plan:
- Reset, then insert tag 3 with both operands ready -> space_available_o = 1 throughout; disp_valid_o = 1 on the cycle after insert; disp_tag_o = 3; entry freed on disp_ready_i.
- Insert tag 1 with op0 waiting on tag 5, then eu_valid_i with eu_tag_i = 5 two cycles later -> disp_valid_o stays 0 until the cycle after the broadcast, then issues tag 1.
- Insert tag 2 with op1 on tag 6 in the same cycle as eu_valid_i with eu_tag_i = 6 -> operand stored ready; tag 2 dispatches in the next cycle.
- Fill all 4 slots (tags 0-3), all waiting on tag 7 -> space_available_o = 0; broadcast tag 7 -> tags dispatch in insertion order 0, 1, 2, 3 with disp_ready_i held at 1.
- Insert tag 4 (ready), hold disp_ready_i = 0, then an older entry tag 0 wakes -> disp_tag_o stays 4 until accepted; tag 0 dispatches next.
- Reset asserted while 3 entries are valid and the stream is stalled -> disp_valid_o = 0 and space_available_o = 1 immediately; no stale dispatch after reset release.
